// File: rtl/craft_cell_serdes.sv
// Block/cell boundary for the nibble-serial CRAFT datapath: serialises 64-bit blocks into
// 16 cells on the load side and reassembles returned cells into blocks on the unload side.
module craft_cell_serdes #(
    parameter int unsigned NCELLS = 16,
    parameter int unsigned CELL_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NCELLS*CELL_W-1:0] in_block,
    output logic [CELL_W-1:0]        cell_out,
    output logic                     cell_valid,
    output logic                     cell_first,
    output logic                     cell_last,
    input  logic [CELL_W-1:0]        cell_in,
    input  logic                     cell_in_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NCELLS*CELL_W-1:0] out_block,
    output logic                     overflow
);

    localparam int unsigned BlkW = NCELLS * CELL_W;
    localparam int unsigned CntW = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NCELLS - 1);

    typedef enum logic {TxIdle, TxShift} tx_state_e;
    typedef enum logic {RxCollect, RxHold} rx_state_e;

    tx_state_e           tx_state_q, tx_state_d;
    logic [BlkW-1:0]     tx_shreg_q, tx_shreg_d;
    logic [CntW-1:0]     tx_cnt_q, tx_cnt_d;

    rx_state_e           rx_state_q, rx_state_d;
    logic [BlkW-1:0]     rx_shreg_q, rx_shreg_d;
    logic [CntW-1:0]     rx_cnt_q, rx_cnt_d;
    logic                overflow_q, overflow_d;

    // ---------------- Load side ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TxIdle;
        end else begin
            tx_state_q <= tx_state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shreg_q <= '0;
            tx_cnt_q   <= '0;
        end else begin
            tx_shreg_q <= tx_shreg_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shreg_d = tx_shreg_q;
        tx_cnt_d   = tx_cnt_q;
        unique case (tx_state_q)
            TxIdle: begin
                if (in_valid) begin
                    tx_state_d = TxShift;
                    tx_shreg_d = in_block;
                    tx_cnt_d   = '0;
                end
            end
            TxShift: begin
                tx_shreg_d = tx_shreg_q << CELL_W;
                tx_cnt_d   = tx_cnt_q + CntW'(1);
                if (tx_cnt_q == LastCnt) begin
                    // Accepting during the last cell keeps the cell stream gapless.
                    tx_cnt_d = '0;
                    if (in_valid) begin
                        tx_shreg_d = in_block;
                    end else begin
                        tx_state_d = TxIdle;
                    end
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_comb begin
        cell_valid = (tx_state_q == TxShift);
        cell_out   = cell_valid ? tx_shreg_q[BlkW-1 -: CELL_W] : '0;
        cell_first = cell_valid && (tx_cnt_q == '0);
        cell_last  = cell_valid && (tx_cnt_q == LastCnt);
        // Gated by rst_n so in_ready reads 0 while reset is held, despite the idle state.
        in_ready   = rst_n && ((tx_state_q == TxIdle) || cell_last);
    end

    // ---------------- Unload side ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RxCollect;
        end else begin
            rx_state_q <= rx_state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shreg_q <= '0;
            rx_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            rx_shreg_q <= rx_shreg_d;
            rx_cnt_q   <= rx_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shreg_d = rx_shreg_q;
        rx_cnt_d   = rx_cnt_q;
        overflow_d = overflow_q;
        unique case (rx_state_q)
            RxCollect: begin
                if (cell_in_valid) begin
                    rx_shreg_d = {rx_shreg_q[BlkW-CELL_W-1:0], cell_in};
                    rx_cnt_d   = rx_cnt_q + CntW'(1);
                    if (rx_cnt_q == LastCnt) begin
                        rx_cnt_d   = '0;
                        rx_state_d = RxHold;
                    end
                end
            end
            RxHold: begin
                if (out_ready) begin
                    rx_state_d = RxCollect;
                    // A cell arriving on the handshake edge starts the next block.
                    if (cell_in_valid) begin
                        rx_shreg_d = {rx_shreg_q[BlkW-CELL_W-1:0], cell_in};
                        rx_cnt_d   = CntW'(1);
                    end
                end else if (cell_in_valid) begin
                    overflow_d = 1'b1;
                end
            end
            default: rx_state_d = RxCollect;
        endcase
    end

    always_comb begin
        out_valid = (rx_state_q == RxHold);
        out_block = rx_shreg_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_craft_cell_serdes.sv
// Directed self-checking bench for craft_cell_serdes: serialisation, loopback reassembly,
// back-to-back loads, overflow, gapped cell input and mid-operation reset.
module tb_craft_cell_serdes;

    localparam logic [63:0] BlkA = 64'h5734F006D8D88A3E;
    localparam logic [63:0] BlkB = 64'h54CD94FFD0670A58;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_block;
    logic [3:0]  cell_out;
    logic        cell_valid;
    logic        cell_first;
    logic        cell_last;
    logic [3:0]  cell_in;
    logic        cell_in_valid;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_block;
    logic        overflow;

    logic        lb;
    logic [3:0]  drv_cell;
    logic        drv_cell_valid;

    int total;
    int bad;

    assign cell_in       = lb ? cell_out : drv_cell;
    assign cell_in_valid = lb ? cell_valid : drv_cell_valid;

    craft_cell_serdes dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_block      (in_block),
        .cell_out      (cell_out),
        .cell_valid    (cell_valid),
        .cell_first    (cell_first),
        .cell_last     (cell_last),
        .cell_in       (cell_in),
        .cell_in_valid (cell_in_valid),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_block     (out_block),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        logic [9:0] obs;
        repeat (2) @(posedge clk);
        #1;
        obs = {in_ready, cell_valid, cell_first, cell_last, cell_out, out_valid, overflow};
        total++;
        if (obs !== 10'h0 || out_block !== 64'h0) begin
            bad++;
            $display("FAIL reset_outputs: got ctl=%h blk=%h want ctl=000 blk=0", obs, out_block);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || cell_valid !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b cv=%b ov=%b want 1 0 0",
                     in_ready, cell_valid, out_valid);
        end
    endtask

    // One block in loopback with out_ready high; checks every cell and the reassembly.
    task automatic test_single(input logic [63:0] blk);
        logic [7:0] obs, exp;
        int         idx;
        lb        = 1'b1;
        out_ready = 1'b1;
        in_block  = blk;
        in_valid  = 1'b1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_accept_ready: got %b want 1", in_ready);
        end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) in_valid = 1'b0;
            obs = {in_ready, cell_valid, cell_first, cell_last, cell_out};
            if (k <= 16) begin
                idx = k - 1;
                exp = {(k == 16), 1'b1, (k == 1), (k == 16), blk[63-4*idx -: 4]};
            end else begin
                exp = 8'h80;
            end
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL single_cell k=%0d: got rdy/v/f/l/cell=%h want %h", k, obs, exp);
            end
            total++;
            if (out_valid !== (k == 17) || overflow !== 1'b0) begin
                bad++;
                $display("FAIL single_out k=%0d: got ov=%b ovf=%b want ov=%b ovf=0",
                         k, out_valid, overflow, (k == 17));
            end
            if (k == 17) begin
                total++;
                if (out_block !== blk) begin
                    bad++;
                    $display("FAIL single_block: got %h want %h", out_block, blk);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  obs, exp;
        logic [63:0] blk;
        int          idx;
        lb        = 1'b1;
        out_ready = 1'b1;
        in_block  = BlkA;
        in_valid  = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) in_block = BlkB;
            if (k == 17) in_valid = 1'b0;
            obs = {in_ready, cell_valid, cell_first, cell_last, cell_out};
            if (k <= 32) begin
                blk = (k <= 16) ? BlkA : BlkB;
                idx = (k - 1) % 16;
                exp = {(idx == 15), 1'b1, (idx == 0), (idx == 15), blk[63-4*idx -: 4]};
            end else begin
                exp = 8'h80;
            end
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL b2b_cell k=%0d: got rdy/v/f/l/cell=%h want %h", k, obs, exp);
            end
            total++;
            if (out_valid !== (k == 17 || k == 33)) begin
                bad++;
                $display("FAIL b2b_out_valid k=%0d: got %b want %b", k, out_valid,
                         (k == 17 || k == 33));
            end
            if (k == 17 || k == 33) begin
                blk = (k == 17) ? BlkA : BlkB;
                total++;
                if (out_block !== blk) begin
                    bad++;
                    $display("FAIL b2b_block k=%0d: got %h want %h", k, out_block, blk);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic exp_ov, exp_ovf;
        lb        = 1'b1;
        out_ready = 1'b0;
        in_block  = BlkA;
        in_valid  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) in_block = BlkB;
            if (k == 17) in_valid = 1'b0;
            exp_ov  = (k >= 17 && k <= 37);
            exp_ovf = (k >= 18);
            total++;
            if (out_valid !== exp_ov || overflow !== exp_ovf) begin
                bad++;
                $display("FAIL ovf_flags k=%0d: got ov=%b ovf=%b want ov=%b ovf=%b",
                         k, out_valid, overflow, exp_ov, exp_ovf);
            end
            if (exp_ov) begin
                total++;
                if (out_block !== BlkA) begin
                    bad++;
                    $display("FAIL ovf_block k=%0d: got %h want %h", k, out_block, BlkA);
                end
            end
            if (k == 37) out_ready = 1'b1;
        end
    endtask

    task automatic test_gaps();
        int   sent;
        int   cyc;
        logic v;
        lb             = 1'b0;
        out_ready      = 1'b1;
        sent           = 0;
        cyc            = 0;
        while (sent < 16 && cyc < 200) begin
            v              = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            drv_cell_valid = v;
            drv_cell       = v ? BlkB[63-4*sent -: 4] : 4'($urandom);
            @(posedge clk);
            #1;
            cyc++;
            if (v) sent++;
            if (sent < 16) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL gaps_early k=%0d sent=%0d: got ov=%b want 0", cyc, sent,
                             out_valid);
                end
            end
        end
        drv_cell_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_block !== BlkB || cell_valid !== 1'b0) begin
            bad++;
            $display("FAIL gaps_block: got ov=%b blk=%h cv=%b want ov=1 blk=%h cv=0",
                     out_valid, out_block, cell_valid, BlkB);
        end
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL gaps_handshake: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] obs;
        lb        = 1'b1;
        out_ready = 1'b1;
        in_block  = BlkA;
        in_valid  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) in_valid = 1'b0;
        end
        total++;
        if (cell_valid !== 1'b1 || cell_out !== 4'h6) begin
            bad++;
            $display("FAIL rstmid_cell7: got cv=%b cell=%h want cv=1 cell=6", cell_valid,
                     cell_out);
        end
        rst_n = 1'b0;
        #1;
        obs = {in_ready, cell_valid, cell_first, cell_last, cell_out, out_valid, overflow};
        total++;
        if (obs !== 10'h0 || out_block !== 64'h0) begin
            bad++;
            $display("FAIL rstmid_outputs: got ctl=%h blk=%h want ctl=000 blk=0", obs,
                     out_block);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (in_ready !== 1'b1 || cell_valid !== 1'b0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_quiet k=%0d: got rdy=%b cv=%b ov=%b want 1 0 0",
                         k, in_ready, cell_valid, out_valid);
            end
        end
        test_single(BlkB);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_block       = '0;
        out_ready      = 1'b0;
        lb             = 1'b0;
        drv_cell       = '0;
        drv_cell_valid = 1'b0;

        test_reset();
        @(posedge clk);
        #1;
        test_single(BlkA);
        test_back_to_back();
        test_overflow();
        test_gaps();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
